// File: rtl/instr_cache_assoc_if.sv
// Fetch-side and memory-side signals of the set-associative instruction cache.
// The cache uses the slave modport; the fetch unit/memory side uses master.
interface instr_cache_assoc_if;
  logic        req;
  logic [31:0] A;
  logic        invalidate;
  logic [31:0] RD;
  logic        ready;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd;

  modport slave (
    input  req, A, invalidate, mem_ack, mem_rd,
    output RD, ready, stall, mem_req, mem_addr
  );

  modport master (
    output req, A, invalidate, mem_ack, mem_rd,
    input  RD, ready, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache_assoc.sv
// N-way set-associative instruction cache: combinational hit lookup, one-word-per-ack
// line fill on a miss, first-invalid / round-robin victim choice, whole-cache invalidate.
module instr_cache_assoc #(
  parameter int LINES     = 64,
  parameter int WAYS      = 2,
  parameter int BLOCKSIZE = 4
) (
  input logic                clk,
  input logic                reset,
  instr_cache_assoc_if.slave bus
);

  localparam int SETBITS  = $clog2(LINES);
  localparam int WAYBITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OFFBITS  = $clog2(BLOCKSIZE);
  localparam int TAGBITS  = 30 - SETBITS - OFFBITS;
  localparam int LINEBITS = 30 - OFFBITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [TAGBITS-1:0]  tag_mem  [WAYS][LINES];
  logic [31:0]         data_mem [WAYS][LINES][BLOCKSIZE];
  logic [LINES-1:0]    valid_mem [WAYS];
  logic [WAYBITS-1:0]  rr_ptr   [LINES];

  logic [SETBITS-1:0]  set_idx;
  logic [OFFBITS-1:0]  word_idx;
  logic [TAGBITS-1:0]  req_tag;
  logic [WAYS-1:0]     hit_way;
  logic                any_hit;
  logic [31:0]         rd_mux;

  logic [LINEBITS-1:0] fill_line;
  logic [SETBITS-1:0]  fill_set;
  logic [TAGBITS-1:0]  fill_tag;
  logic [OFFBITS-1:0]  wcnt;
  logic [WAYBITS-1:0]  victim;
  logic                victim_rr;
  logic [WAYBITS-1:0]  victim_sel;
  logic                victim_sel_rr;
  logic [WAYBITS-1:0]  rr_next;
  logic                pend_inv;

  logic                idle;
  logic                start_miss;
  logic                last_ack;
  logic                apply_inv;
  logic                unused_addr_bits;

  assign set_idx          = bus.A[SETBITS+OFFBITS+1:OFFBITS+2];
  assign word_idx         = bus.A[OFFBITS+1:2];
  assign req_tag          = bus.A[31:SETBITS+OFFBITS+2];
  assign unused_addr_bits = ^bus.A[1:0];

  assign fill_set = fill_line[SETBITS-1:0];
  assign fill_tag = fill_line[LINEBITS-1:SETBITS];

  // Tags are unique within a set, so the read data is a plain AND-OR of the hitting ways.
  always_comb begin
    hit_way = '0;
    rd_mux  = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = valid_mem[w][set_idx] && (tag_mem[w][set_idx] == req_tag);
      rd_mux     = rd_mux | ({32{hit_way[w]}} & data_mem[w][set_idx][word_idx]);
    end
  end

  assign any_hit = |hit_way;

  // Lowest-index invalid way wins; only when every way is valid does the pointer decide.
  always_comb begin
    victim_sel    = rr_ptr[set_idx];
    victim_sel_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[w][set_idx]) begin
        victim_sel    = WAYBITS'(w);
        victim_sel_rr = 1'b0;
      end
    end
  end

  assign rr_next = (rr_ptr[fill_set] == WAYBITS'(WAYS - 1)) ? '0 : rr_ptr[fill_set] + 1'b1;

  assign idle       = (state == IDLE);
  assign start_miss = idle && bus.req && !any_hit && !bus.invalidate;
  assign last_ack   = (state == FILL) && bus.mem_ack && (wcnt == OFFBITS'(BLOCKSIZE - 1));
  assign apply_inv  = (idle && bus.invalidate) ||
                      ((state == DONE) && (pend_inv || bus.invalidate));

  assign bus.ready    = idle && bus.req && any_hit && !bus.invalidate;
  assign bus.RD       = rd_mux;
  assign bus.stall    = !idle || start_miss;
  assign bus.mem_req  = (state == FILL);
  assign bus.mem_addr = (state == FILL) ? {fill_line, wcnt, 2'b00} : 32'd0;

  // Control state, valid bits and replacement pointers; a pending invalidate
  // waits for the fill to finish so it also wipes the line just brought in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill_line <= '0;
      wcnt      <= '0;
      victim    <= '0;
      victim_rr <= 1'b0;
      pend_inv  <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_mem[w] <= '0;
      end
      for (int s = 0; s < LINES; s++) begin
        rr_ptr[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_miss) begin
            state                         <= FILL;
            fill_line                     <= bus.A[31:OFFBITS+2];
            victim                        <= victim_sel;
            victim_rr                     <= victim_sel_rr;
            valid_mem[victim_sel][set_idx] <= 1'b0;
            wcnt                          <= '0;
          end
        end
        FILL: begin
          if (bus.invalidate) begin
            pend_inv <= 1'b1;
          end
          if (bus.mem_ack) begin
            wcnt <= wcnt + 1'b1;
          end
          if (last_ack) begin
            state                       <= DONE;
            valid_mem[victim][fill_set] <= 1'b1;
            if (victim_rr) begin
              rr_ptr[fill_set] <= rr_next;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          pend_inv <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (apply_inv) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_mem[w] <= '0;
        end
        for (int s = 0; s < LINES; s++) begin
          rr_ptr[s] <= '0;
        end
      end
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if ((state == FILL) && bus.mem_ack) begin
      data_mem[victim][fill_set][wcnt] <= bus.mem_rd;
      if (last_ack) begin
        tag_mem[victim][fill_set] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Randomised bench for instr_cache_assoc: a set/way/round-robin reference model
// plus a memory responder with random ack gaps, all checks through checkOutput.
module tb_instr_cache_assoc;

  localparam int LINES     = 4;
  localparam int WAYS      = 2;
  localparam int BLOCKSIZE = 4;
  localparam int SETBITS   = $clog2(LINES);
  localparam int OFFBITS   = $clog2(BLOCKSIZE);
  localparam logic [31:0] KEY       = 32'hA5A5_0000;
  localparam logic [31:0] LINE_MASK = ~32'(BLOCKSIZE * 4 - 1);

  logic clk;
  logic reset;

  instr_cache_assoc_if bus ();

  instr_cache_assoc #(
    .LINES    (LINES),
    .WAYS     (WAYS),
    .BLOCKSIZE(BLOCKSIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: which tags are resident in each set, plus the replacement pointer.
  bit          m_valid [WAYS][LINES];
  int unsigned m_tag   [WAYS][LINES];
  int          m_rr    [LINES];

  function automatic int unsigned setOf(input logic [31:0] a);
    return (a >> (OFFBITS + 2)) % LINES;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] a);
    return a >> (SETBITS + OFFBITS + 2);
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][setOf(a)] && m_tag[w][setOf(a)] == tagOf(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelFill(input logic [31:0] a);
    int s = setOf(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[w][s] && v < 0) v = w;
    if (v < 0) begin
      v       = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[v][s] = 1'b1;
    m_tag[v][s]   = tagOf(a);
  endfunction

  function automatic void modelClear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < LINES; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < LINES; s++) m_rr[s] = 0;
  endfunction

  function automatic logic [31:0] wordData(input logic [31:0] a);
    return (a & ~32'h3) ^ KEY;
  endfunction

  // Memory responder: owns its counters; the main process only reads them.
  logic [31:0] exp_line_base = 32'd0;
  int          max_gap       = 0;
  int          fill_cycles   = 0;
  int          ack_count     = 0;
  int          bad_addr      = 0;

  initial begin
    int gap = 0;
    int idx = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rd  = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        fill_cycles++;
        if (bus.mem_addr !== exp_line_base + 32'(idx * 4)) bad_addr++;
        if (gap == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rd  = bus.mem_addr ^ KEY;
          idx++;
          ack_count++;
          gap = int'($urandom_range(0, max_gap));
        end else begin
          bus.mem_ack = 1'b0;
          gap--;
        end
      end else begin
        bus.mem_ack = 1'b0;
        idx = 0;
      end
    end
  end

  // One fetch of addr; inv_mid pulses invalidate (and scrambles A/req) inside the fill.
  task automatic applyStimulus(input logic [31:0] addr, input bit inv_mid);
    bit exp_hit;
    bit done;
    int stall_cycles;
    int fc0, ac0, ba0;
    @(negedge clk);
    bus.req       = 1'b1;
    bus.A         = addr;
    exp_line_base = addr & LINE_MASK;
    exp_hit       = modelHit(addr);
    fc0 = fill_cycles;
    ac0 = ack_count;
    ba0 = bad_addr;
    #1;
    checkOutput("ready", bus.ready, exp_hit);
    if (exp_hit) begin
      checkOutput("rd_hit", bus.RD, wordData(addr));
      checkOutput("stall_hit", bus.stall, 0);
      checkOutput("mem_req_hit", bus.mem_req, 0);
      bus.req = 1'b0;
    end else begin
      checkOutput("stall_miss", bus.stall, 1);
      stall_cycles = 1;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (inv_mid && c == 1) begin
          bus.invalidate = 1'b1;
          bus.A          = $urandom;
          bus.req        = 1'($urandom_range(0, 1));
        end else if (inv_mid && c == 2) begin
          bus.invalidate = 1'b0;
          bus.A          = addr;
          bus.req        = 1'b0;
        end
        #1;
        if (bus.stall) stall_cycles++;
        else done = 1'b1;
      end
      checkOutput("fill_timeout", done, 1);
      checkOutput("fill_acks", ack_count - ac0, BLOCKSIZE);
      checkOutput("fill_addr_errs", bad_addr - ba0, 0);
      checkOutput("stall_len", stall_cycles, (fill_cycles - fc0) + 2);
      modelFill(addr);
      if (inv_mid) modelClear();
      bus.req = 1'b1;
      bus.A   = addr;
      #1;
      exp_hit = modelHit(addr);
      checkOutput("ready_after_fill", bus.ready, exp_hit);
      if (exp_hit) checkOutput("rd_after_fill", bus.RD, wordData(addr));
      else checkOutput("stall_after_inv", bus.stall, 1);
      bus.req = 1'b0;
    end
  endtask

  // Invalidate in IDLE together with a request; it must win over the miss.
  task automatic pulseInvalidate(input logic [31:0] addr);
    @(negedge clk);
    bus.invalidate = 1'b1;
    bus.req        = 1'b1;
    bus.A          = addr;
    #1;
    checkOutput("ready_inv", bus.ready, 0);
    checkOutput("stall_inv", bus.stall, 0);
    @(negedge clk);
    bus.invalidate = 1'b0;
    bus.req        = 1'b0;
    #1;
    checkOutput("mem_req_inv", bus.mem_req, 0);
    checkOutput("stall_after_inv_idle", bus.stall, 0);
    modelClear();
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] t = 32'($urandom_range(0, 5));
    logic [31:0] s = 32'($urandom_range(0, LINES - 1));
    logic [31:0] w = 32'($urandom_range(0, BLOCKSIZE - 1));
    return (t << (SETBITS + OFFBITS + 2)) | (s << (OFFBITS + 2)) | (w << 2);
  endfunction

  initial begin
    bit got_ack;
    int r;
    reset          = 1'b0;
    bus.req        = 1'b0;
    bus.A          = 32'd0;
    bus.invalidate = 1'b0;
    modelClear();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", bus.ready, 0);
    checkOutput("reset_stall", bus.stall, 0);
    checkOutput("reset_mem_req", bus.mem_req, 0);
    checkOutput("reset_mem_addr", bus.mem_addr, 0);
    reset = 1'b1;

    $display("[TB] cold miss, hit latency, replacement");
    applyStimulus(32'h100, 1'b0);
    applyStimulus(32'h108, 1'b0);
    applyStimulus(32'h200, 1'b0);
    applyStimulus(32'h300, 1'b0);
    applyStimulus(32'h204, 1'b0);
    applyStimulus(32'h10C, 1'b0);
    applyStimulus(32'h308, 1'b0);
    applyStimulus(32'h200, 1'b0);

    $display("[TB] ack gaps");
    max_gap = 3;
    applyStimulus(32'h010, 1'b0);
    applyStimulus(32'h024, 1'b0);
    applyStimulus(32'h01C, 1'b0);

    $display("[TB] invalidate during fill and in idle");
    applyStimulus(32'h400, 1'b1);
    applyStimulus(32'h024, 1'b0);
    pulseInvalidate(32'h500);
    applyStimulus(32'h024, 1'b0);

    $display("[TB] reset during fill");
    @(negedge clk);
    bus.req       = 1'b1;
    bus.A         = 32'h100;
    exp_line_base = 32'h100;
    r = ack_count;
    got_ack = 1'b0;
    for (int c = 0; c < 50 && !got_ack; c++) begin
      @(negedge clk);
      #1;
      if (ack_count > r) got_ack = 1'b1;
    end
    checkOutput("first_ack_timeout", got_ack, 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset   = 1'b0;
    bus.req = 1'b0;
    #1;
    checkOutput("mid_reset_mem_req", bus.mem_req, 0);
    checkOutput("mid_reset_stall", bus.stall, 0);
    checkOutput("mid_reset_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    modelClear();
    applyStimulus(32'h100, 1'b0);

    $display("[TB] random fetches");
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) pulseInvalidate(randAddr());
      else applyStimulus(randAddr(), r == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
